// File: rtl/sstv_pkg.sv
// Shared constants and slot-state encoding for the SSTV bitmap RAM arbiter.
package sstv_pkg;

  localparam int SSTV_COLS   = 160;
  localparam int SSTV_ROWS   = 120;
  localparam int SSTV_PIXELS = SSTV_COLS * SSTV_ROWS;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_TX   = 2'd1,
    SLOT_WR   = 2'd2,
    SLOT_RD   = 2'd3
  } slot_e;

endpackage

// File: rtl/sstv_starve_cnt.sv
// Saturating blocked-cycle counter; hit pulses on the cycle
// that makes the LIMIT-th consecutive blocked cycle.
module sstv_starve_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic blocked,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] cnt;

  assign hit = blocked && (cnt == MAX - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!blocked) begin
      cnt <= '0;
    end else if (cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sstv_bitmap_arb.sv
// Single-port 1-bit bitmap RAM arbiter: T priority, W/R round-robin.
// Optional SSTV_ARB_CYCLE_STEAL_EN: repeat T addresses yield the slot.
module sstv_bitmap_arb
  import sstv_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int BITMAP_DEPTH = SSTV_PIXELS,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_active,
  input  logic [ADDR_W-1:0] tx_addr,
  output logic              tx_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic              rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              addr_err,
  output logic              starve
);

  slot_e state, state_nx;
  logic  rr_last_rd;
  logic  slot_oor_q, slot_oor_nx;
  logic  tx_ok, wr_ok, rd_ok;
  logic  tx_own, pick_w, steal;
  logic  rd_hold;
  logic  wr_hit, rd_hit;

  assign tx_ok = 32'(tx_addr) < BITMAP_DEPTH;
  assign wr_ok = 32'(wr_addr) < BITMAP_DEPTH;
  assign rd_ok = 32'(rd_addr) < BITMAP_DEPTH;

`ifdef SSTV_ARB_CYCLE_STEAL_EN
  logic [ADDR_W-1:0] last_tx_addr;
  logic              stolen_q;

  // Pixel already captured (or still in flight) for this address.
  assign steal = tx_active && (tx_addr == last_tx_addr) &&
                 (state == SLOT_TX || stolen_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_tx_addr <= '0;
      stolen_q     <= 1'b0;
    end else begin
      stolen_q <= steal;
      if (tx_own) last_tx_addr <= tx_addr;
    end
  end
`else
  assign steal = 1'b0;
`endif

  assign tx_own = reset_n & tx_active & ~steal;
  assign pick_w = wr_req & (~rd_req | rr_last_rd);
  assign wr_gnt = reset_n & ~tx_own & pick_w;
  assign rd_gnt = reset_n & ~tx_own & rd_req & ~pick_w;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 1'b0;
    state_nx    = SLOT_IDLE;
    slot_oor_nx = 1'b0;
    unique case (1'b1)
      tx_own: begin
        mem_en      = tx_ok;
        mem_addr    = tx_addr;
        state_nx    = SLOT_TX;
        slot_oor_nx = ~tx_ok;
      end
      wr_gnt: begin
        mem_en      = wr_ok;
        mem_we      = wr_ok;
        mem_addr    = wr_addr;
        mem_wdata   = wr_data;
        state_nx    = SLOT_WR;
        slot_oor_nx = ~wr_ok;
      end
      rd_gnt: begin
        mem_en      = rd_ok;
        mem_addr    = rd_addr;
        state_nx    = SLOT_RD;
        slot_oor_nx = ~rd_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SLOT_IDLE;
    else          state <= state_nx;
  end

  assign rd_valid = (state == SLOT_RD);
  assign rd_data  = rd_valid ? (mem_rdata & ~slot_oor_q) : rd_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_rd <= 1'b1;
      slot_oor_q <= 1'b0;
      tx_data    <= 1'b0;
      rd_hold    <= 1'b0;
      addr_err   <= 1'b0;
      starve     <= 1'b0;
    end else begin
      slot_oor_q <= slot_oor_nx;
      rd_hold    <= rd_data;
      if (wr_gnt)      rr_last_rd <= 1'b0;
      else if (rd_gnt) rr_last_rd <= 1'b1;
      if (state == SLOT_TX) tx_data <= mem_rdata & ~slot_oor_q;
      if (slot_oor_nx)      addr_err <= 1'b1;
      if (wr_hit | rd_hit)  starve <= 1'b1;
    end
  end

  sstv_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_wr_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .blocked (wr_req & ~wr_gnt),
    .hit     (wr_hit)
  );

  sstv_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_rd_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .blocked (rd_req & ~rd_gnt),
    .hit     (rd_hit)
  );

endmodule
